regfile_write_arbiter: RTL

Arbitrates the single write port of `register_file` between the in-order WB stage and the multi-cycle multiply/divide unit (`md`). Results from `md` are buffered in a small FIFO and drained into idle write-port cycles. A pending-destination scoreboard tells decode when a source register still awaits an `md` result. The block sits between WB/`md` and `register_file`, and drives `RegWrite`/`WriteAddress`/`WriteData` directly.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 47 ++++
 rtl/regfile_write_arbiter_fifo.sv | 53 +++++
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Purpose: shared widths, write-request struct and grant encoding for the register-file write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  // One buffered md result: destination register and value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Owner of the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WB = 2'd1,
    GRANT_MD = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Purpose: bundles the WB, md, decode and register-file write signals of the arbiter.
// Latency: n/a (wires only).
// Backpressure: wb_stall holds the WB stage, md_ready holds the md source.
// Ports: master = pipeline side (drives requests, sees stalls/writes),
//        slave  = arbiter side.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;

  logic              md_issue;
  logic [ADDR_W-1:0] md_issue_addr;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_data;

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              hazard_stall;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output wb_we, wb_addr, wb_data,
    output md_issue, md_issue_addr, md_valid, md_addr, md_data,
    output rs_addr, rt_addr,
    input  wb_stall, md_ready, hazard_stall,
    input  RegWrite, WriteAddress, WriteData
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  md_issue, md_issue_addr, md_valid, md_addr, md_data,
    input  rs_addr, rt_addr,
    output wb_stall, md_ready, hazard_stall,
    output RegWrite, WriteAddress, WriteData
  );

endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// Purpose: small synchronous FIFO holding md results awaiting a free write-port cycle.
// Latency: an entry is visible at head the cycle after its push (no write-through).
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: clk/rst, push + pushData, pop, full, empty, head (oldest entry).
module wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wr_req_t pushData,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wr_req_t head
);

  localparam int PW = $clog2(DEPTH);

  // One extra MSB on each pointer distinguishes full from empty when the
  // index bits are equal.
  logic [PW:0] wrPtr;
  logic [PW:0] rdPtr;
  wr_req_t     mem [DEPTH];

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PW-1:0] == rdPtr[PW-1:0]) && (wrPtr[PW] != rdPtr[PW]);
  assign head  = mem[rdPtr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop && !empty) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  // Storage needs no reset: only pointer-validated entries are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wrPtr[PW-1:0]] <= pushData;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register-file write port between WB and buffered md results, tracks md-pending registers.
// Latency: WB 0 cycles (same-cycle write); md >= 1 cycle from accept to RegWrite, <= STARVE_MAX+1 per entry under WB load.
// Backpressure: md_ready = FIFO not full (registered occupancy); wb_stall asserted only on a forced drain.
// Ports: clk, rst (sync, active-high), bus (slave modport): wb_* request/stall,
//        md_issue*, md_valid/ready/addr/data, rs/rt_addr -> hazard_stall,
//        RegWrite/WriteAddress/WriteData to register_file.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int             CW        = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

  grant_e              grant;
  logic                fifoFull;
  logic                fifoEmpty;
  wr_req_t             fifoHead;
  wr_req_t             pushData;
  logic                push;
  logic                pop;
  logic                mdReady;
  logic                forceDrain;
  logic [CW-1:0]       starveCnt;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pendingNext;
  logic                rsPending;
  logic                rtPending;

  // md_ready comes from registered occupancy only, so a full FIFO refuses
  // a push even in the cycle it pops.
  assign mdReady  = !rst && !fifoFull;
  assign push     = bus.md_valid && mdReady;
  assign pushData = '{addr: bus.md_addr, data: bus.md_data};

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (fifoHead)
  );

  // WB has lost nothing but its slot: it re-presents next cycle.
  assign forceDrain = bus.wb_we && !fifoEmpty && (starveCnt == STARVE_LIM);

  always_comb begin
    grant = IDLE;
    if (!rst) begin
      if (bus.wb_we && !forceDrain) begin
        grant = GRANT_WB;
      end else if (!fifoEmpty) begin
        grant = GRANT_MD;
      end
    end
  end

  assign pop = (grant == GRANT_MD);

  always_comb begin
    bus.RegWrite     = (grant != IDLE);
    bus.WriteAddress = bus.wb_addr;
    bus.WriteData    = bus.wb_data;
    if (grant == GRANT_MD) begin
      bus.WriteAddress = fifoHead.addr;
      bus.WriteData    = fifoHead.data;
    end
  end

  assign bus.wb_stall = !rst && forceDrain;
  assign bus.md_ready = mdReady;

  // Counts WB wins while md results wait; any drain or an empty FIFO
  // restarts the fairness window.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (pop || fifoEmpty) begin
      starveCnt <= '0;
    end else if ((grant == GRANT_WB) && (starveCnt != STARVE_LIM)) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Set is applied after clear so a re-issue to the register being drained
  // keeps it pending.
  always_comb begin
    pendingNext = pending;
    if (pop) begin
      pendingNext[fifoHead.addr] = 1'b0;
    end
    if (bus.md_issue && (bus.md_issue_addr != '0)) begin
      pendingNext[bus.md_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

  // R0 is hard-wired zero in register_file, so it never creates a hazard.
  assign rsPending        = (bus.rs_addr != '0) && pending[bus.rs_addr];
  assign rtPending        = (bus.rt_addr != '0) && pending[bus.rt_addr];
  assign bus.hazard_stall = !rst && (rsPending || rtPending);

endmodule
